// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op/state encodings for the HI/LO multiply-divide unit
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MADD  = 3'd2,
        OP_MSUB  = 3'd3,
        OP_DIV   = 3'd4,
        OP_DIVU  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } opCode_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    function automatic logic is_mul_class(opCode_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// rtl/div_iter_core.sv - restoring divider on operand magnitudes, one quotient bit per Step
module div_iter_core
    import hilo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Load,
    input  logic              Step,
    input  logic              IsSigned,
    input  logic [DATA_W-1:0] Dividend,
    input  logic [DATA_W-1:0] Divisor,
    output logic [DATA_W-1:0] Quotient,
    output logic [DATA_W-1:0] Remainder
);

    logic [DATA_W-1:0] remReg;
    logic [DATA_W-1:0] quotReg;
    logic [DATA_W-1:0] divReg;
    logic              negQ;
    logic              negR;
    logic              dividendNeg;
    logic              divisorNeg;
    logic [DATA_W:0]   trial;

    assign dividendNeg = IsSigned & Dividend[DATA_W-1];
    assign divisorNeg  = IsSigned & Divisor[DATA_W-1];

    // quotReg doubles as the dividend shift register; its MSB feeds the partial remainder
    assign trial = {remReg, quotReg[DATA_W-1]} - {1'b0, divReg};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            remReg  <= '0;
            quotReg <= '0;
            divReg  <= '0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
        end else if (Load) begin
            remReg  <= '0;
            quotReg <= dividendNeg ? -Dividend : Dividend;
            divReg  <= divisorNeg ? -Divisor : Divisor;
            negQ    <= dividendNeg ^ divisorNeg;
            negR    <= dividendNeg;
        end else if (Step) begin
            if (!trial[DATA_W]) begin
                remReg  <= trial[DATA_W-1:0];
                quotReg <= {quotReg[DATA_W-2:0], 1'b1};
            end else begin
                remReg  <= {remReg[DATA_W-2:0], quotReg[DATA_W-1]};
                quotReg <= {quotReg[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign Quotient  = negQ ? -quotReg : quotReg;
    assign Remainder = negR ? -remReg : remReg;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - multi-cycle HI/LO multiply/divide unit with Busy/Done handshake
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] OperandA,
    input  logic [DATA_W-1:0] OperandB,
    input  logic              Flush,
    output logic              Busy,
    output logic              Done,
    output logic              DivByZero,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo
);

    localparam int PROD_W   = 2 * DATA_W;
    localparam int CNT_MAX  = (DATA_W > MUL_CYCLES) ? DATA_W : MUL_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int MUL_LAST = (MUL_CYCLES >= 2) ? MUL_CYCLES - 2 : 0;

    state_t            state;
    state_t            nextState;
    opCode_t           opIn;
    opCode_t           opReg;
    opCode_t           opSel;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] hiReg;
    logic [DATA_W-1:0] loReg;
    logic [DATA_W-1:0] newHi;
    logic [DATA_W-1:0] newLo;
    logic [DATA_W-1:0] divQuot;
    logic [DATA_W-1:0] divRem;
    logic              wrHi;
    logic              wrLo;
    logic              setDbz;
    logic              mtPulse;
    logic              dbzReg;
    logic              mtDone;
    logic              mulSigned;
    logic              launch;
    logic [PROD_W-1:0] prodNow;
    logic [PROD_W-1:0] mulResult;
    logic [PROD_W-1:0] mulCommit;

    assign opIn      = opCode_t'(Op);
    assign launch    = Start && !Flush;
    assign mulSigned = (opIn != OP_MULTU);
    assign prodNow   = {{DATA_W{mulSigned & OperandA[DATA_W-1]}}, OperandA}
                     * {{DATA_W{mulSigned & OperandB[DATA_W-1]}}, OperandB};

    // The comb product is the first stage; the registered chain lands it on the FIN-entry edge.
    generate
        if (MUL_CYCLES == 1) begin : gen_mul_comb
            assign mulResult = prodNow;
        end else begin : gen_mul_pipe
            logic [PROD_W-1:0] prodPipe [MUL_CYCLES-1];
            always_ff @(posedge Clk) begin
                prodPipe[0] <= prodNow;
                for (int k = 1; k < MUL_CYCLES - 1; k++) begin
                    prodPipe[k] <= prodPipe[k-1];
                end
            end
            assign mulResult = prodPipe[MUL_CYCLES-2];
        end
    endgenerate

    // In IDLE the op is still on the port (MUL_CYCLES=1 commits straight from IDLE)
    assign opSel = (state == ST_IDLE) ? opIn : opReg;

    always_comb begin
        mulCommit = mulResult;
        case (opSel)
            OP_MADD: mulCommit = {hiReg, loReg} + mulResult;
            OP_MSUB: mulCommit = {hiReg, loReg} - mulResult;
            default: mulCommit = mulResult;
        endcase
    end

    div_iter_core #(.DATA_W(DATA_W)) u_div (
        .Clk       (Clk),
        .Rst       (Rst),
        .Load      (state == ST_IDLE),
        .Step      (state == ST_DIV),
        .IsSigned  (opIn == OP_DIV),
        .Dividend  (OperandA),
        .Divisor   (OperandB),
        .Quotient  (divQuot),
        .Remainder (divRem)
    );

    // HI/LO are written on the edge that enters FIN, so they are already valid while Done is high
    always_comb begin
        nextState = state;
        wrHi      = 1'b0;
        wrLo      = 1'b0;
        newHi     = hiReg;
        newLo     = loReg;
        setDbz    = 1'b0;
        mtPulse   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    if (is_mul_class(opIn)) begin
                        if (MUL_CYCLES == 1) begin
                            nextState = ST_FIN;
                            wrHi      = 1'b1;
                            wrLo      = 1'b1;
                            newHi     = mulCommit[PROD_W-1:DATA_W];
                            newLo     = mulCommit[DATA_W-1:0];
                        end else begin
                            nextState = ST_MUL;
                        end
                    end else if (opIn == OP_DIV || opIn == OP_DIVU) begin
                        if (OperandB == '0) begin
                            nextState = ST_FIN;
                            wrHi      = 1'b1;
                            wrLo      = 1'b1;
                            newHi     = OperandA;
                            newLo     = '1;
                            setDbz    = 1'b1;
                        end else begin
                            nextState = ST_DIV;
                        end
                    end else if (opIn == OP_MTHI) begin
                        wrHi    = 1'b1;
                        newHi   = OperandA;
                        mtPulse = 1'b1;
                    end else begin
                        wrLo    = 1'b1;
                        newLo   = OperandA;
                        mtPulse = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (Flush) begin
                    nextState = ST_IDLE;
                end else if (cnt == CNT_W'(MUL_LAST)) begin
                    nextState = ST_FIN;
                    wrHi      = 1'b1;
                    wrLo      = 1'b1;
                    newHi     = mulCommit[PROD_W-1:DATA_W];
                    newLo     = mulCommit[DATA_W-1:0];
                end
            end
            ST_DIV: begin
                if (Flush) begin
                    nextState = ST_IDLE;
                end else if (cnt == CNT_W'(DATA_W - 1)) begin
                    nextState = ST_FIX;
                end
            end
            ST_FIX: begin
                if (Flush) begin
                    nextState = ST_IDLE;
                end else begin
                    nextState = ST_FIN;
                    wrHi      = 1'b1;
                    wrLo      = 1'b1;
                    newHi     = divRem;
                    newLo     = divQuot;
                end
            end
            ST_FIN:  nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            opReg  <= OP_MULT;
            hiReg  <= '0;
            loReg  <= '0;
            dbzReg <= 1'b0;
            mtDone <= 1'b0;
        end else begin
            state  <= nextState;
            cnt    <= (state == nextState && state != ST_IDLE) ? cnt + 1'b1 : '0;
            dbzReg <= setDbz;
            mtDone <= mtPulse;
            if (state == ST_IDLE && launch) begin
                opReg <= opIn;
            end
            if (wrHi) begin
                hiReg <= newHi;
            end
            if (wrLo) begin
                loReg <= newLo;
            end
        end
    end

    assign Busy      = (state != ST_IDLE);
    assign Done      = (state == ST_FIN) || mtDone;
    assign DivByZero = (state == ST_FIN) && dbzReg;
    assign Hi        = hiReg;
    assign Lo        = loReg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - scoreboard bench for hilo_muldiv_unit (DATA_W=32, MUL_CYCLES=4)
module tb_hilo_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    always #5 Clk = ~Clk;

    hilo_muldiv_unit #(.DATA_W(32), .MUL_CYCLES(4)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .Flush     (Flush),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] refHi;
    logic [31:0] refLo;
    int          passCount = 0;
    int          checkCount = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        checkCount++;
        if (got === want) begin
            passCount++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t computeExp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = $signed(a);
        ib = $signed(b);
        e.hi  = refHi;
        e.lo  = refLo;
        e.dbz = 1'b0;
        e.lat = 4;
        case (op)
            3'd0: {e.hi, e.lo} = 64'(sa * sb);
            3'd1: {e.hi, e.lo} = ua * ub;
            3'd2: {e.hi, e.lo} = {refHi, refLo} + 64'(sa * sb);
            3'd3: {e.hi, e.lo} = {refHi, refLo} - 64'(sa * sb);
            3'd4, 3'd5: begin
                e.lat = 34;
                if (b == 32'd0) begin
                    e.hi  = a;
                    e.lo  = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                    e.lat = 1;
                end else if (op == 3'd5) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'd0;
                end else begin
                    e.lo = ia / ib;
                    e.hi = ia % ib;
                end
            end
            3'd6: begin e.hi = a; e.lat = 1; end
            default: begin e.lo = a; e.lat = 1; end
        endcase
        return e;
    endfunction

    // flushAt: cycle after the Start edge in which Flush is raised (0 = never)
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flushAt, input bit holdStart, input bit chkLat);
        exp_t e;
        exp_t got;
        bit   aborted;
        int   doneAt;
        int   holdLimit;
        e = computeExp(op, a, b);
        aborted   = (flushAt > 0) && (flushAt < e.lat);
        holdLimit = aborted ? flushAt : e.lat;
        doneAt    = 0;
        expQ.push_back(e);
        @(negedge Clk);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b; Flush = 1'b0;
        for (int k = 1; k <= e.lat + 2; k++) begin
            @(negedge Clk);
            Start    = holdStart && (k <= holdLimit);
            Op       = 3'($urandom_range(7));
            OperandA = $urandom;
            OperandB = $urandom;
            if (chkLat && k == 1) checkVal("busyRise", {31'b0, Busy}, {31'b0, op < 3'd6});
            if (Done) begin
                if (expQ.size() == 0) begin
                    checkVal("unexpectedDone", {31'b0, Done}, 32'd0);
                end else begin
                    got = expQ.pop_front();
                    checkVal("hi", Hi, got.hi);
                    checkVal("lo", Lo, got.lo);
                    checkVal("divByZero", {31'b0, DivByZero}, {31'b0, got.dbz});
                    if (chkLat) checkVal("latency", doneAt == 0 ? k : -1, got.lat);
                    refHi = got.hi;
                    refLo = got.lo;
                end
                doneAt = k;
            end else if (chkLat && k < e.lat) begin
                checkVal("hiHeld", Hi, refHi);
            end
            if (aborted && k == flushAt) void'(expQ.pop_back());
            if (aborted && k == flushAt + 1) checkVal("busyAfterFlush", {31'b0, Busy}, 32'd0);
            Flush = (k == flushAt);
        end
        Flush = 1'b0;
        Start = 1'b0;
        if (aborted) begin
            checkVal("hiKept", Hi, refHi);
            checkVal("loKept", Lo, refLo);
        end else begin
            checkVal("doneSeen", {31'b0, doneAt != 0}, 32'd1);
        end
    endtask

    function automatic logic [31:0] pickVal();
        logic [31:0] specials [5];
        specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(99) < 25) return specials[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;
        int          fAt;
        Rst = 1'b1; Start = 1'b0; Flush = 1'b0; Op = 3'd0; OperandA = '0; OperandB = '0;
        refHi = '0; refLo = '0;
        repeat (2) @(negedge Clk);
        checkVal("rstBusy", {31'b0, Busy}, 32'd0);
        checkVal("rstDone", {31'b0, Done}, 32'd0);
        checkVal("rstDbz", {31'b0, DivByZero}, 32'd0);
        checkVal("rstHi", Hi, 32'd0);
        checkVal("rstLo", Lo, 32'd0);
        Rst = 1'b0;

        runOp(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, 1'b1);
        checkVal("multuHi", Hi, 32'h0000_0001);
        checkVal("multuLo", Lo, 32'hFFFF_FFFE);

        runOp(3'd6, 32'd5, 32'd0, 0, 1'b0, 1'b1);
        runOp(3'd7, 32'd7, 32'd0, 0, 1'b0, 1'b1);
        runOp(3'd2, 32'hFFFF_FFFD, 32'd4, 0, 1'b0, 1'b1);
        checkVal("maddHi", Hi, 32'h0000_0004);
        checkVal("maddLo", Lo, 32'hFFFF_FFFB);
        runOp(3'd3, 32'hFFFF_FFFD, 32'd4, 0, 1'b0, 1'b1);
        checkVal("msubHi", Hi, 32'h0000_0005);
        checkVal("msubLo", Lo, 32'h0000_0007);

        runOp(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b1);
        checkVal("divLo", Lo, 32'hFFFF_FFFD);
        checkVal("divHi", Hi, 32'hFFFF_FFFF);
        runOp(3'd5, 32'd7, 32'd0, 0, 1'b0, 1'b1);
        checkVal("dbzLo", Lo, 32'hFFFF_FFFF);
        checkVal("dbzHi", Hi, 32'd7);

        runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b1);
        checkVal("minIntLo", Lo, 32'h8000_0000);
        checkVal("minIntHi", Hi, 32'd0);

        runOp(3'd5, 32'd1000, 32'd7, 10, 1'b1, 1'b1);

        // Flush beats Start while idle
        @(negedge Clk);
        Start = 1'b1; Flush = 1'b1; Op = 3'd6; OperandA = 32'hDEAD_BEEF;
        @(negedge Clk);
        Start = 1'b0; Flush = 1'b0;
        checkVal("flushStartDone", {31'b0, Done}, 32'd0);
        checkVal("flushStartHi", Hi, refHi);
        Start = 1'b1; Flush = 1'b1; Op = 3'd1;
        @(negedge Clk);
        Start = 1'b0; Flush = 1'b0;
        checkVal("flushStartBusy", {31'b0, Busy}, 32'd0);

        // reset in the middle of a MULT
        Start = 1'b1; Op = 3'd0; OperandA = 32'd3; OperandB = 32'd5;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        checkVal("midRstHi", Hi, 32'd0);
        checkVal("midRstLo", Lo, 32'd0);
        checkVal("midRstBusy", {31'b0, Busy}, 32'd0);
        refHi = '0; refLo = '0;
        expQ.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            checkVal("midRstNoDone", {31'b0, Done}, 32'd0);
        end

        for (int n = 0; n < 600; n++) begin
            rop = 3'($urandom_range(7));
            ra  = pickVal();
            rb  = ($urandom_range(99) < 8) ? 32'd0 : pickVal();
            lat = (rop < 3'd4) ? 4 : (rop < 3'd6) ? ((rb == 32'd0) ? 1 : 34) : 1;
            fAt = 0;
            for (int k = 1; k <= lat; k++) begin
                if (fAt == 0 && $urandom_range(99) < 5) fAt = k;
            end
            runOp(rop, ra, rb, fAt, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
